// File: rtl/clock_period_meter_if.sv
// Signal bundle between the period meter and whatever consumes its measurements.
// The meter drives the results; the consumer side supplies the waveform to be measured.
interface clock_period_meter_if #(
   parameter int CNT_W = 32
);
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             period_valid;
   logic             locked;
   logic             timeout;

   modport master (
      input  sig_in,
      output period, high_time, period_valid, locked, timeout
   );

   modport slave (
      output sig_in,
      input  period, high_time, period_valid, locked, timeout
   );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous waveform in clkin cycles,
// with lock indication and a stall timeout.
module clock_period_meter #(
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 100000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clkin,
   input  logic                   reset,
   clock_period_meter_if.master   mif
);

   typedef enum logic {WAIT_EDGE, MEASURE} state_t;

   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_time_q, high_time_d;
   logic                   period_valid_q, period_valid_d;
   logic                   locked_q, locked_d;
   logic                   timeout_q, timeout_d;

   logic sync_out;
   logic rise;
   logic fall;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_q;
   assign fall     = ~sync_out & prev_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], mif.sig_in};
      prev_d = sync_out;
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      period_d       = period_q;
      high_time_d    = high_time_q;
      period_valid_d = 1'b0;
      locked_d       = locked_q;
      timeout_d      = 1'b0;
      case (state_q)
         WAIT_EDGE: begin
            cnt_d = '0;
            if (rise) begin
               cnt_d   = ONE_C;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            // A rise on the timeout cycle still counts as a valid period.
            if (rise) begin
               period_d       = cnt_q;
               period_valid_d = 1'b1;
               locked_d       = 1'b1;
               cnt_d          = ONE_C;
            end else if (cnt_q == TIMEOUT_C) begin
               timeout_d   = 1'b1;
               locked_d    = 1'b0;
               period_d    = '0;
               high_time_d = '0;
               cnt_d       = '0;
               state_d     = WAIT_EDGE;
            end else begin
               cnt_d = cnt_q + ONE_C;
               if (fall) begin
                  high_time_d = cnt_q;
               end
            end
         end
         default: state_d = WAIT_EDGE;
      endcase
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_q        <= WAIT_EDGE;
         sync_q         <= '0;
         prev_q         <= 1'b0;
         cnt_q          <= '0;
         period_q       <= '0;
         high_time_q    <= '0;
         period_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         sync_q         <= sync_d;
         prev_q         <= prev_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         high_time_q    <= high_time_d;
         period_valid_q <= period_valid_d;
         locked_q       <= locked_d;
         timeout_q      <= timeout_d;
      end
   end

   assign mif.period       = period_q;
   assign mif.high_time    = high_time_q;
   assign mif.period_valid = period_valid_q;
   assign mif.locked       = locked_q;
   assign mif.timeout      = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: edge-time reference model, table of waveforms,
// random waveforms and hand sequences for timeout and mid-measurement reset.
module tb_clock_period_meter;

   localparam int CNT_W       = 32;
   localparam int TIMEOUT     = 100;
   localparam int SYNC_STAGES = 2;

   logic clkin;
   logic reset;

   clock_period_meter_if #(.CNT_W(CNT_W)) mif ();

   clock_period_meter #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clkin(clkin),
      .reset(reset),
      .mif  (mif)
   );

   initial begin
      clkin = 1'b0;
      forever #5 clkin = ~clkin;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pv_cnt = 0;
   int to_cnt = 0;
   int last_pv_cyc = 0;
   int to_cyc = 0;

   // Reference model: remembers the cycle of the last detected rise and
   // derives results as differences of edge times.
   bit          hist[$];
   bit          m_meas;
   int          m_t0;
   logic [31:0] m_period;
   logic [31:0] m_high;
   logic        m_pv;
   logic        m_lock;
   logic        m_to;

   typedef struct {
      int          high;
      int          low;
      int          n;
      logic [31:0] exp_period;
      logic [31:0] exp_high;
   } vec_t;

   vec_t vecs[5];

   task automatic model_clear();
      hist.delete();
      for (int i = 0; i < SYNC_STAGES + 2; i++) hist.push_back(1'b0);
      m_meas = 1'b0; m_t0 = 0; m_period = '0; m_high = '0;
      m_pv = 1'b0; m_lock = 1'b0; m_to = 1'b0;
   endtask

   task automatic model_step();
      bit r, f;
      int el;
      r = hist[1] & ~hist[0];
      f = ~hist[1] & hist[0];
      m_pv = 1'b0;
      m_to = 1'b0;
      if (!m_meas) begin
         if (r) begin
            m_meas = 1'b1;
            m_t0   = cyc;
         end
      end else begin
         el = cyc - m_t0;
         if (r) begin
            m_period = el;
            m_pv     = 1'b1;
            m_lock   = 1'b1;
            m_t0     = cyc;
         end else if (el == TIMEOUT) begin
            m_to = 1'b1; m_lock = 1'b0; m_period = '0; m_high = '0; m_meas = 1'b0;
         end else if (f) begin
            m_high = el;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // One clkin cycle: model advances on the edge, DUT is checked 1 time unit
   // later, then sig_in takes value v for the following cycle.
   task automatic tick(input logic v);
      @(posedge clkin);
      cyc++;
      if (reset) begin
         model_clear();
      end else begin
         hist.push_back(mif.sig_in);
         void'(hist.pop_front());
         model_step();
      end
      #1;
      chk("period", mif.period, m_period);
      chk("high_time", mif.high_time, m_high);
      chk("period_valid", 32'(mif.period_valid), 32'(m_pv));
      chk("locked", 32'(mif.locked), 32'(m_lock));
      chk("timeout", 32'(mif.timeout), 32'(m_to));
      if (mif.period_valid) begin
         pv_cnt++;
         last_pv_cyc = cyc;
      end
      if (mif.timeout) begin
         to_cnt++;
         to_cyc = cyc;
      end
      mif.sig_in = v;
   endtask

   task automatic wave(input int high, input int low, input int n);
      for (int p = 0; p < n; p++) begin
         for (int i = 0; i < high; i++) tick(1'b1);
         for (int i = 0; i < low; i++) tick(1'b0);
      end
   endtask

   initial begin
      int pv0, to0, since, first_pv;
      vecs[0] = '{high: 10, low: 10, n: 4, exp_period: 20,  exp_high: 10};
      vecs[1] = '{high: 3,  low: 7,  n: 4, exp_period: 10,  exp_high: 3};
      vecs[2] = '{high: 15, low: 15, n: 4, exp_period: 30,  exp_high: 15};
      vecs[3] = '{high: 50, low: 50, n: 3, exp_period: 100, exp_high: 50};
      vecs[4] = '{high: 1,  low: 9,  n: 4, exp_period: 10,  exp_high: 1};

      reset = 1'b1;
      mif.sig_in = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) tick(1'b0);
      reset = 1'b0;

      // First rise after reset: measurement starts, nothing reported yet.
      pv0 = pv_cnt;
      wave(10, 10, 1);
      chk("first_rise_no_valid", pv_cnt - pv0, 0);
      chk("first_rise_not_locked", 32'(mif.locked), 0);

      for (int v = 0; v < 5; v++) begin
         to0 = to_cnt;
         wave(vecs[v].high, vecs[v].low, vecs[v].n);
         chk("tbl_period", mif.period, vecs[v].exp_period);
         chk("tbl_high_time", mif.high_time, vecs[v].exp_high);
         chk("tbl_locked", 32'(mif.locked), 1);
         chk("tbl_no_timeout", to_cnt - to0, 0);
      end

      // Stall low: one timeout exactly TIMEOUT cycles after the last rise.
      pv0 = pv_cnt;
      to0 = to_cnt;
      for (int i = 0; i < 130; i++) tick(1'b0);
      chk("stall_timeout_count", to_cnt - to0, 1);
      chk("stall_timeout_delay", to_cyc - last_pv_cyc, TIMEOUT);
      chk("stall_no_valid", pv_cnt - pv0, 0);
      chk("stall_locked", 32'(mif.locked), 0);
      chk("stall_period", mif.period, 0);
      chk("stall_high_time", mif.high_time, 0);

      for (int s = 0; s < 8; s++) begin
         wave($urandom_range(1, 40), $urandom_range(1, 40), 3);
      end

      // Reset seven cycles into a measurement, then re-acquire.
      since = -1;
      for (int i = 0; i < 60 && since < 6; i++) begin
         tick((i % 20) < 10);
         if (mif.period_valid) since = 0;
         else if (since >= 0) since++;
      end
      chk("pre_reset_reached", since, 6);
      mif.sig_in = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_period", mif.period, 0);
      chk("async_high_time", mif.high_time, 0);
      chk("async_valid", 32'(mif.period_valid), 0);
      chk("async_locked", 32'(mif.locked), 0);
      chk("async_timeout", 32'(mif.timeout), 0);
      for (int i = 0; i < 3; i++) tick(1'b0);
      reset = 1'b0;
      pv0 = pv_cnt;
      first_pv = -1;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 20; i++) begin
            tick(i < 10);
            if (mif.period_valid && first_pv < 0) first_pv = int'(mif.period);
         end
      end
      chk("post_reset_valid_count", pv_cnt - pv0, 2);
      chk("post_reset_first_period", first_pv, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
